mac_preact: RTL and testbench



---
 rtl/mac_preact.sv | 141 ++++++++++++++
 tb/tb_mac_preact.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_preact.sv
// rtl/mac_preact.sv - saturating signed multiply-accumulate feeding the ReLU stage.
// Optional MAC_PREACT_BIAS_EN adds a bias port loaded into the accumulator on every clear.
module mac_preact #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 20,
    parameter int N_TERMS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_ovf
`ifdef MAC_PREACT_BIAS_EN
    ,
    input  logic signed [ACC_W-1:0]  bias
`endif
);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    localparam logic [7:0]         LAST    = 8'(N_TERMS - 1);
    localparam logic [ACC_W-1:0]   ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]   ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_ovf_q, out_ovf_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]      prod_ext;
    logic signed [ACC_W:0]      sum;
    logic signed [ACC_W-1:0]    clamped;
    logic                       step_ovf;
    logic signed [ACC_W-1:0]    clear_val;

`ifdef MAC_PREACT_BIAS_EN
    assign clear_val = bias;
`else
    assign clear_val = '0;
`endif

    // One extra guard bit: overflow shows up as disagreement of the top two sum bits.
    always_comb begin
        prod     = x * w;
        prod_ext = {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        sum      = {acc_q[ACC_W-1], acc_q} + prod_ext;
        step_ovf = sum[ACC_W] != sum[ACC_W-1];
        if (step_ovf) begin
            clamped = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            clamped = sum[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (clr) begin
            state_d     = ST_ACC;
            acc_d       = clear_val;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid && in_ready_q) begin
                        acc_d = clamped;
                        ovf_d = ovf_q | step_ovf;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == LAST) begin
                            state_d     = ST_OUT;
                            out_valid_d = 1'b1;
                            out_data_d  = clamped;
                            out_ovf_d   = ovf_q | step_ovf;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_d     = ST_ACC;
                        acc_d       = clear_val;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_ovf_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
        in_ready_d = (state_d == ST_ACC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= clear_val;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_preact.sv
// tb/tb_mac_preact.sv - directed self-checking bench for mac_preact (N_TERMS=4 and N_TERMS=1 instances).
module tb_mac_preact;

    logic clk = 1'b0;
    logic rst, clr, in_valid, out_ready;
    logic signed [7:0] x, w;
    logic in_ready, out_valid, out_ovf;
    logic signed [15:0] out_data;

    logic clr1, in1_valid, out1_ready;
    logic signed [7:0] x1, w1;
    logic in1_ready, out1_valid, out1_ovf;
    logic signed [15:0] out1_data;
`ifdef MAC_PREACT_BIAS_EN
    logic signed [15:0] bias, bias1;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mac_preact #(.DATA_W(8), .ACC_W(16), .N_TERMS(4)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
`ifdef MAC_PREACT_BIAS_EN
        , .bias(bias)
`endif
    );

    mac_preact #(.DATA_W(8), .ACC_W(16), .N_TERMS(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr1),
        .in_valid(in1_valid), .in_ready(in1_ready), .x(x1), .w(w1),
        .out_valid(out1_valid), .out_ready(out1_ready),
        .out_data(out1_data), .out_ovf(out1_ovf)
`ifdef MAC_PREACT_BIAS_EN
        , .bias(bias1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] xv, input logic signed [7:0] wv);
        in_valid = 1'b1;
        x = xv;
        w = wv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        total++;
        if (out_data !== 16'sd0 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: out_data=%0d out_ovf=%b required 0/0", out_data, out_ovf);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(1, 5);
        send(2, -1);
        send(3, 2);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: out_valid=%b required 0 after 3 beats", out_valid);
        end
        send(4, -3);
        total++;
        if (out_valid !== 1'b1 || out_data !== -16'sd3 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: valid=%b data=%0d ovf=%b in_ready=%b required 1/-3/0/0",
                     out_valid, out_data, out_ovf, in_ready);
        end
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'sd0) begin
            bad++;
            $display("FAIL basic_after: valid=%b in_ready=%b data=%0d required 0/1/0",
                     out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) send(-128, -128);
        total++;
        if (out_data !== 16'sd32767 || out_ovf !== 1'b1) begin
            bad++;
            $display("FAIL sat_pos: data=%0d ovf=%b required 32767/1", out_data, out_ovf);
        end
        handshake();
        for (int i = 0; i < 4; i++) send(1, 1);
        total++;
        if (out_data !== 16'sd4 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL sat_next: data=%0d ovf=%b required 4/0", out_data, out_ovf);
        end
        handshake();
        for (int i = 0; i < 4; i++) send(-128, 127);
        total++;
        if (out_data !== -16'sd32768 || out_ovf !== 1'b1) begin
            bad++;
            $display("FAIL sat_neg: data=%0d ovf=%b required -32768/1", out_data, out_ovf);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) send(10, 10);
        in_valid = 1'b1;
        x = 50;
        w = 50;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'sd400 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d in_ready=%b required 1/400/0",
                         i, out_valid, out_data, in_ready);
            end
        end
        in_valid = 1'b0;
        handshake();
        for (int i = 0; i < 4; i++) send(1, 2);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'sd8) begin
            bad++;
            $display("FAIL bp_next: valid=%b data=%0d required 1/8", out_valid, out_data);
        end
        handshake();
    endtask

    task automatic test_gaps();
        logic [6:0] pat;
        pat = 7'b1101001;
        x = 2;
        w = 3;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            tick();
            total++;
            if (out_valid !== (i == 6)) begin
                bad++;
                $display("FAIL gaps_valid%0d: out_valid=%b required %b", i, out_valid, (i == 6));
            end
        end
        in_valid = 1'b0;
        total++;
        if (out_data !== 16'sd24) begin
            bad++;
            $display("FAIL gaps_data: data=%0d required 24", out_data);
        end
        handshake();
    endtask

    task automatic test_clr_acc();
        send(5, 5);
        send(5, 5);
        clr = 1'b1;
        in_valid = 1'b1;
        x = 9;
        w = 9;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) send(1, 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_cnt: out_valid=%b required 0 after 3 fresh beats", out_valid);
        end
        send(1, 1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'sd4 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL clr_acc: valid=%b data=%0d ovf=%b required 1/4/0", out_valid, out_data, out_ovf);
        end
        handshake();
    endtask

    task automatic test_rst_out();
        for (int i = 0; i < 4; i++) send(7, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_out: valid=%b data=%0d in_ready=%b required 0/0/1", out_valid, out_data, in_ready);
        end
        for (int i = 0; i < 4; i++) send(1, 1);
        total++;
        if (out_data !== 16'sd4) begin
            bad++;
            $display("FAIL rst_next: data=%0d required 4", out_data);
        end
        handshake();
    endtask

    task automatic test_clr_out();
        for (int i = 0; i < 4; i++) send(3, 3);
        clr = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_out: valid=%b data=%0d in_ready=%b required 0/0/1", out_valid, out_data, in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_out_extra: out_valid=%b required 0", out_valid);
        end
        for (int i = 0; i < 4; i++) send(-1, 1);
        total++;
        if (out_data !== -16'sd4) begin
            bad++;
            $display("FAIL clr_out_next: data=%0d required -4", out_data);
        end
        handshake();
    endtask

    task automatic test_n1();
        out1_ready = 1'b1;
        in1_valid = 1'b1;
        x1 = -7;
        w1 = 6;
        tick();
        total++;
        if (out1_valid !== 1'b1 || out1_data !== -16'sd42 || in1_ready !== 1'b0) begin
            bad++;
            $display("FAIL n1_first: valid=%b data=%0d in_ready=%b required 1/-42/0", out1_valid, out1_data, in1_ready);
        end
        x1 = 3;
        w1 = 3;
        tick();
        total++;
        if (out1_valid !== 1'b0 || in1_ready !== 1'b1) begin
            bad++;
            $display("FAIL n1_gap: valid=%b in_ready=%b required 0/1", out1_valid, in1_ready);
        end
        tick();
        in1_valid = 1'b0;
        total++;
        if (out1_valid !== 1'b1 || out1_data !== 16'sd9) begin
            bad++;
            $display("FAIL n1_second: valid=%b data=%0d required 1/9", out1_valid, out1_data);
        end
        tick();
        out1_ready = 1'b0;
    endtask

`ifdef MAC_PREACT_BIAS_EN
    task automatic test_bias();
        bias = 100;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        send(3, 4);
        send(-5, 2);
        send(0, 0);
        send(0, 0);
        total++;
        if (out_data !== 16'sd102 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL bias_first: data=%0d ovf=%b required 102/0", out_data, out_ovf);
        end
        bias = -7;
        handshake();
        for (int i = 0; i < 4; i++) send(1, 1);
        total++;
        if (out_data !== -16'sd3) begin
            bad++;
            $display("FAIL bias_second: data=%0d required -3", out_data);
        end
        bias = 0;
        handshake();
    endtask
`endif

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = 0;
        w = 0;
        clr1 = 1'b0;
        in1_valid = 1'b0;
        out1_ready = 1'b0;
        x1 = 0;
        w1 = 0;
`ifdef MAC_PREACT_BIAS_EN
        bias = 0;
        bias1 = 0;
`endif
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_gaps();
        test_clr_acc();
        test_rst_out();
        test_clr_out();
        test_n1();
`ifdef MAC_PREACT_BIAS_EN
        test_bias();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
